// File: rtl/arduino_link_rx_if.sv
// Serial link bundle between the Arduino line and the game top level.
// rx flows in; decoded pulses, key map and debug state flow out.
interface arduino_link_rx_if #(
   parameter int N_TECLAS = 13
);
   logic                rx;
   logic                right_arrow_pressed;
   logic                left_arrow_pressed;
   logic                enter_pressed;
   logic [N_TECLAS-1:0] botoes;
   logic [7:0]          dado_recebido;
   logic                pronto;
   logic                erro_quadro;
   logic                comando_invalido;
   logic [2:0]          db_estado;

   // Arduino / consumer side: drives the line, observes decoded results.
   modport master (
      output rx,
      input  right_arrow_pressed, left_arrow_pressed, enter_pressed,
      input  botoes, dado_recebido, pronto, erro_quadro, comando_invalido,
      input  db_estado
   );

   // Receiver side.
   modport slave (
      input  rx,
      output right_arrow_pressed, left_arrow_pressed, enter_pressed,
      output botoes, dado_recebido, pronto, erro_quadro, comando_invalido,
      output db_estado
   );
endinterface

// File: rtl/arduino_link_rx.sv
// UART 8N1 receiver decoding Arduino command bytes into menu pulses and a held key map.
// Latency: outputs update 1 clock after the stop-bit sample edge (~2 clocks sync + 9.5 bit times from start edge).
// Backpressure: none; the serial line is free-running and every decoded pulse lasts exactly one clock.
module arduino_link_rx #(
   parameter int CLOCK_FREQ = 50_000_000,
   parameter int BAUD       = 9600,
   parameter int N_TECLAS   = 13
) (
   input  logic             clock,
   input  logic             reset,
   arduino_link_rx_if.slave link
);
   localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] FIM_BIT  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] MEIO_BIT = CNT_W'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {
      OCIOSO     = 3'd0,
      INICIO     = 3'd1,
      DADOS      = 3'd2,
      PARADA     = 3'd3,
      DECODIFICA = 3'd4,
      ESPERA     = 3'd5
   } estado_t;

   estado_t             estado, prox_estado;
   logic                rx_meta, rx_s;
   logic [1:0]          sync_valido;
   logic                armado;
   logic [CNT_W-1:0]    cnt;
   logic [2:0]          bit_idx;
   logic [7:0]          byte_sr;

   logic                tick;
   logic                amostra_bit;
   logic                decodifica;
   logic                falha_quadro;
   logic [5:0]          tecla;
   logic                tecla_ok;
   logic [N_TECLAS-1:0] mascara;
   logic                cmd_right, cmd_left, cmd_enter;
   logic                cmd_press, cmd_release, cmd_zero, cmd_invalido;

   logic                right_q, left_q, enter_q, pronto_q, erro_q, invalido_q;
   logic [N_TECLAS-1:0] botoes_q;
   logic [7:0]          dado_q;

   // Start detection stays disarmed after reset until the line has been seen idle
   // through a filled synchroniser, so a reset mid-frame cannot lock onto a data bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         rx_meta     <= 1'b1;
         rx_s        <= 1'b1;
         sync_valido <= 2'b00;
         armado      <= 1'b0;
      end else begin
         rx_meta     <= link.rx;
         rx_s        <= rx_meta;
         sync_valido <= {sync_valido[0], 1'b1};
         if (sync_valido[1] && rx_s)
            armado <= 1'b1;
      end
   end

   // State register
   always_ff @(posedge clock) begin
      if (reset)
         estado <= OCIOSO;
      else
         estado <= prox_estado;
   end

   // Next-state logic
   always_comb begin
      prox_estado = estado;
      unique case (estado)
         OCIOSO:     if (armado && !rx_s) prox_estado = INICIO;
         INICIO:     if (tick) prox_estado = rx_s ? OCIOSO : DADOS;
         DADOS:      if (tick && bit_idx == 3'd7) prox_estado = PARADA;
         PARADA:     if (tick) prox_estado = rx_s ? DECODIFICA : ESPERA;
         DECODIFICA: prox_estado = OCIOSO;
         ESPERA:     if (rx_s) prox_estado = OCIOSO;
         default:    prox_estado = OCIOSO;
      endcase
   end

   // Output/control decode
   always_comb begin
      tick         = ((estado == INICIO) && (cnt == MEIO_BIT)) ||
                     (((estado == DADOS) || (estado == PARADA)) && (cnt == FIM_BIT));
      amostra_bit  = (estado == DADOS) && tick;
      decodifica   = (estado == DECODIFICA);
      falha_quadro = (estado == PARADA) && tick && !rx_s;

      tecla        = byte_sr[5:0];
      tecla_ok     = (32'(tecla) < N_TECLAS);
      mascara      = N_TECLAS'(1) << tecla;
      cmd_right    = (byte_sr == 8'h52);
      cmd_left     = (byte_sr == 8'h4C);
      cmd_enter    = (byte_sr == 8'h45);
      cmd_press    = (byte_sr[7:6] == 2'b10) && tecla_ok;
      cmd_release  = (byte_sr[7:6] == 2'b11) && tecla_ok;
      cmd_zero     = (byte_sr == 8'h00);
      cmd_invalido = !(cmd_right || cmd_left || cmd_enter ||
                       cmd_press || cmd_release || cmd_zero);
   end

   // Bit timer restarts on every state entry and on every terminal count.
   always_ff @(posedge clock) begin
      if (reset || (prox_estado != estado) || tick)
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         bit_idx <= 3'd0;
         byte_sr <= 8'h00;
      end else if (estado == INICIO) begin
         bit_idx <= 3'd0;
      end else if (amostra_bit) begin
         bit_idx <= bit_idx + 3'd1;
         byte_sr <= {rx_s, byte_sr[7:1]};
      end
   end

   // Registered results; pulses are rebuilt from scratch every clock so they never stretch.
   always_ff @(posedge clock) begin
      if (reset) begin
         right_q    <= 1'b0;
         left_q     <= 1'b0;
         enter_q    <= 1'b0;
         pronto_q   <= 1'b0;
         erro_q     <= 1'b0;
         invalido_q <= 1'b0;
         botoes_q   <= '0;
         dado_q     <= 8'h00;
      end else begin
         right_q    <= decodifica && cmd_right;
         left_q     <= decodifica && cmd_left;
         enter_q    <= decodifica && cmd_enter;
         pronto_q   <= decodifica;
         erro_q     <= falha_quadro;
         invalido_q <= decodifica && cmd_invalido;
         if (decodifica) begin
            dado_q <= byte_sr;
            if (cmd_zero)
               botoes_q <= '0;
            else if (cmd_press)
               botoes_q <= botoes_q | mascara;
            else if (cmd_release)
               botoes_q <= botoes_q & ~mascara;
         end
      end
   end

   assign link.right_arrow_pressed = right_q;
   assign link.left_arrow_pressed  = left_q;
   assign link.enter_pressed       = enter_q;
   assign link.pronto              = pronto_q;
   assign link.erro_quadro         = erro_q;
   assign link.comando_invalido    = invalido_q;
   assign link.botoes              = botoes_q;
   assign link.dado_recebido       = dado_q;
   assign link.db_estado           = estado;
endmodule

// File: doc/arduino_link_rx.md
Name: arduino_link_rx

Overview:
- UART 8N1 receiver for the Arduino-to-FPGA link.
- Deserialises command bytes sent by the Arduino and decodes them into:
  - one-cycle menu navigation pulses, which feed the right/left/enter inputs of the game top level;
  - a held 13-bit piano key map, which feeds the botoes input.
- It is the counterpart of the 4-bit arduino_out status path that runs FPGA-to-Arduino.

Parameters:
- CLOCK_FREQ, 50_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate. CLKS_PER_BIT = CLOCK_FREQ/BAUD (integer division, must be >= 4).
- N_TECLAS, 13, number of key-map bits.

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- rx  in  1  asynchronous serial line; idle high.
- right_arrow_pressed  out  1  one-cycle pulse on command 'R' (0x52).
- left_arrow_pressed  out  1  one-cycle pulse on command 'L' (0x4C).
- enter_pressed  out  1  one-cycle pulse on command 'E' (0x45).
- botoes  out  N_TECLAS  held key map; bit n=1 means key n is pressed.
- dado_recebido  out  8  last byte received with a valid stop bit.
- pronto  out  1  one-cycle pulse each time a valid byte completes.
- erro_quadro  out  1  one-cycle pulse when the stop bit is 0.
- comando_invalido  out  1  one-cycle pulse when a valid byte matches no command.
- db_estado  out  3  current FSM state code, for debug.

Behaviour:
- Synchroniser:
  - rx passes through a 2-flop synchroniser; both flops reset to 1.
  - All sampling uses the synchronised value rx_s.
- Bit timer: a counter reset on every state entry; `tick` fires when the counter reaches its terminal value.
- FSM, with state codes:
  - OCIOSO=0:
    - Waits for rx_s=0, then → INICIO.
  - INICIO=1:
    - At count CLKS_PER_BIT/2-1, samples rx_s.
    - rx_s=0 → DADOS, with the bit index cleared.
    - rx_s=1 → OCIOSO (glitch rejected; no pulse).
  - DADOS=2:
    - Every CLKS_PER_BIT clocks, shifts rx_s into the byte, LSB first.
    - After the 8th bit → PARADA.
  - PARADA=3:
    - After CLKS_PER_BIT clocks, samples rx_s.
    - rx_s=1 → DECODIFICA.
    - rx_s=0 → erro_quadro pulse, → ESPERA.
  - DECODIFICA=4:
    - Lasts a single cycle; updates outputs, then → OCIOSO.
  - ESPERA=5:
    - Waits for rx_s=1, then → OCIOSO.
    - Prevents a break condition from being re-read as a start bit.
- Decode (all registered outputs; they are visible during the cycle after entry into DECODIFICA):
  - dado_recebido <= byte; pronto=1.
  - 0x52 → right_arrow_pressed=1; 0x4C → left_arrow_pressed=1; 0x45 → enter_pressed=1.
  - 0x80|n (bits 7:6=10), n<N_TECLAS → botoes[n] <= 1.
  - 0xC0|n (bits 7:6=11), n<N_TECLAS → botoes[n] <= 0.
  - 0x00 → botoes <= 0 (all keys released).
  - Any other value, including n>=N_TECLAS → comando_invalido=1; botoes unchanged.
- Pulse rules:
  - Every pulse output is high for exactly 1 clock per frame.
  - Pulses are never stretched or merged across back-to-back frames.
- Latency: pulses appear 1 clock after the stop-bit sample edge.
- Sampling point: each data bit is sampled at the bit centre ±1 clock.
- Back-to-back frames: a start bit that arrives immediately after the stop bit is accepted, because DECODIFICA lasts only 1 cycle.
- Reset:
  - All outputs go to 0, botoes=0, state=OCIOSO, synchroniser=1.
  - Reset mid-frame discards the partial byte; no pulse is produced.
  - The next frame must begin with a fresh start edge.
- Key-map updates: press and release of the same key in consecutive frames apply in order; the last one wins.

Test Plan:
All scenarios use CLOCK_FREQ=1000, BAUD=100, giving 10 clocks per bit.
- Send 0x52 → right_arrow_pressed high for exactly 1 cycle; pronto=1; dado_recebido=0x52; other pulses stay 0; botoes=0.
- Send 0x83, then 0x8C, then 0xC3 → botoes goes 0x0008, then 0x1008, then 0x1000; three pronto pulses.
- Send 0x8D (n=13) and 0x7F → comando_invalido pulses twice; botoes unchanged; no arrow pulses.
- Frame 0x45 with the stop bit forced to 0 → erro_quadro 1 cycle; enter_pressed stays 0.
  - Holding rx low for 30 clocks and then releasing produces no further pulses.
  - A following valid 0x45 gives enter_pressed=1.
- Start glitch: rx low for 3 clocks → no pronto, FSM returns to OCIOSO. Then 0x4C, 0x52 back-to-back with no idle gap → left pulse, then right pulse, in order.
- Reset asserted in the middle of the data bits of 0x85 → no pulse and botoes=0. A subsequent 0x85 sets botoes[5]=1. Sending 0x00 clears botoes to 0.
